stopwatch_ctrl: RTL and testbench

//  Sequencing controller for the stopwatch time-counter datapath: start/stop, pause, clear, count-down preset load, and expiry alarm.

---
 rtl/stopwatch_ctrl_pkg.sv | 20 ++
 rtl/stopwatch_ctrl_button_edge.sv | 24 ++
 rtl/stopwatch_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch sequencing controller: FSM state
// encodings (visible on the state port) and default timing constants.
package stopwatch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_PROG  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int TW_DEF             = 23;
  localparam int SEC_MS_DEF         = 1000;
  localparam int MIN_MS_DEF         = 60000;
  localparam int MAX_MS_DEF         = 5999999;
  localparam int DEFAULT_PRESET_DEF = 60000;
  localparam int BEEP_CYCLES_DEF    = 50000000;

endpackage

// File: rtl/stopwatch_ctrl_button_edge.sv
// Rising-edge detector for an already-synchronised button level.
// The previous-level register resets to 1 so that a button held down while
// reset is released is not mistaken for a fresh press.
module button_edge (
  input  logic clock,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  logic prev;

  // Remember last cycle's level; reset high to swallow a held button.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev <= 1'b1;
    end else begin
      prev <= btn;
    end
  end

  assign press = btn & ~prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller. Turns debounced button levels into
// count enable / direction / clear / load commands for the millisecond
// time counter, owns the count-down preset (edited in program mode) and
// times the expiry beep.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TW                = TW_DEF,
  parameter int SEC_MS            = SEC_MS_DEF,
  parameter int MIN_MS            = MIN_MS_DEF,
  parameter int MAX_MS            = MAX_MS_DEF,
  parameter int DEFAULT_PRESET_MS = DEFAULT_PRESET_DEF,
  parameter int BEEP_CYCLES       = BEEP_CYCLES_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          startstop,
  input  logic          clear,
  input  logic          prog,
  input  logic          up,
  input  logic          increment,
  input  logic          min,
  input  logic          cnt_zero,
  input  logic          cnt_max,
  output logic          cnt_en,
  output logic          cnt_up,
  output logic          cnt_clear,
  output logic          cnt_load,
  output logic [TW-1:0] preset_ms,
  output logic [2:0]    state,
  output logic          beep
);

  // Beep counter is sized to hold BEEP_CYCLES itself; keep at least one bit.
  localparam int BW = (BEEP_CYCLES < 1) ? 1 : $clog2(BEEP_CYCLES + 1);

  localparam logic [TW:0]   SEC_STEP     = (TW + 1)'(SEC_MS);
  localparam logic [TW:0]   MIN_STEP     = (TW + 1)'(MIN_MS);
  localparam logic [TW:0]   MAX_LIM      = (TW + 1)'(MAX_MS);
  localparam logic [TW-1:0] PRESET_RESET = TW'(DEFAULT_PRESET_MS);
  localparam logic [BW-1:0] BEEP_INIT    = BW'(BEEP_CYCLES);
  localparam logic [BW-1:0] BEEP_ONE     = BW'(1);
  localparam logic          BEEP_ON      = (BEEP_CYCLES != 0);

  // Preset after one increment step; one extra bit catches the overflow
  // so anything past the largest legal preset wraps back to zero.
  function automatic logic [TW-1:0] preset_after_inc(input logic [TW-1:0] cur,
                                                     input logic          use_min);
    logic [TW:0] sum;
    sum = {1'b0, cur} + (use_min ? MIN_STEP : SEC_STEP);
    if (sum > MAX_LIM) begin
      return '0;
    end
    return sum[TW-1:0];
  endfunction

  state_t        st_q, st_d;
  logic          dir_q, dir_d;
  logic [TW-1:0] preset_q, preset_d;
  logic          clr_d, ld_d;
  logic [BW-1:0] bcnt_q;
  logic          beep_q;
  logic          ss_press, clr_press, inc_press;

  button_edge u_ss_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .btn     (startstop),
    .press   (ss_press)
  );

  button_edge u_clr_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .btn     (clear),
    .press   (clr_press)
  );

  button_edge u_inc_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .btn     (increment),
    .press   (inc_press)
  );

  // Next state, direction, preset edits, clear/load requests and the
  // combinational count enable (dropped the same cycle the limit is seen).
  always_comb begin
    st_d     = st_q;
    dir_d    = dir_q;
    preset_d = preset_q;
    clr_d    = 1'b0;
    ld_d     = 1'b0;
    cnt_en   = 1'b0;

    case (st_q)
      ST_IDLE: begin
        if (clr_press) begin
          st_d = ST_IDLE;
        end else if (prog) begin
          st_d = ST_PROG;
        end else if (ss_press && (up || (preset_q != '0))) begin
          // Counting down from a zero preset would expire instantly.
          dir_d = up;
          clr_d = up;
          ld_d  = ~up;
          st_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        cnt_en = ~(dir_q ? cnt_max : cnt_zero);
        if (clr_press) begin
          st_d = ST_IDLE;
        end else if (ss_press) begin
          st_d = ST_PAUSE;
        end else if (!dir_q && cnt_zero) begin
          st_d = ST_DONE;
        end else if (dir_q && cnt_max) begin
          st_d = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        if (clr_press) begin
          st_d = ST_IDLE;
        end else if (prog) begin
          st_d = ST_PROG;
        end else if (ss_press) begin
          st_d = ST_RUN;
        end
      end

      ST_PROG: begin
        if (clr_press) begin
          preset_d = '0;
        end else if (!prog) begin
          st_d = ST_IDLE;
        end else if (inc_press) begin
          preset_d = preset_after_inc(preset_q, min);
        end
      end

      ST_DONE: begin
        if (clr_press || ss_press) begin
          st_d = ST_IDLE;
        end
      end

      default: begin
        st_d = ST_IDLE;
      end
    endcase

    // Every arrival in IDLE re-primes the datapath for the selected direction.
    if ((st_d == ST_IDLE) && (st_q != ST_IDLE)) begin
      dir_d = up;
      clr_d = up;
      ld_d  = ~up;
    end
  end

  // Control registers: state, direction, preset and the one-cycle pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q      <= ST_IDLE;
      dir_q     <= 1'b1;
      preset_q  <= PRESET_RESET;
      cnt_clear <= 1'b0;
      cnt_load  <= 1'b0;
    end else begin
      st_q      <= st_d;
      dir_q     <= dir_d;
      preset_q  <= preset_d;
      cnt_clear <= clr_d;
      cnt_load  <= ld_d;
    end
  end

  // Beep timer: armed on entry to DONE, counts down while DONE persists,
  // and is forced off the moment DONE is left.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bcnt_q <= '0;
      beep_q <= 1'b0;
    end else if ((st_d == ST_DONE) && (st_q != ST_DONE)) begin
      bcnt_q <= BEEP_INIT;
      beep_q <= BEEP_ON;
    end else if ((st_d == ST_DONE) && (st_q == ST_DONE)) begin
      if (bcnt_q > BEEP_ONE) begin
        bcnt_q <= bcnt_q - BEEP_ONE;
      end else begin
        bcnt_q <= '0;
        beep_q <= 1'b0;
      end
    end else begin
      bcnt_q <= '0;
      beep_q <= 1'b0;
    end
  end

  assign cnt_up    = dir_q;
  assign preset_ms = preset_q;
  assign state     = st_q;
  assign beep      = beep_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: vector table, hand sequences for the
// multi-cycle cases, then random stimulus against a behavioural model.
module tb_stopwatch_ctrl;

  localparam int TW = 23;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic ss = 0, clr = 0, prg = 0, up = 1, inc = 0, mn = 0, cz = 0, cm = 0;

  logic          en_a, cu_a, cc_a, cl_a, bp_a;
  logic [TW-1:0] pr_a;
  logic [2:0]    st_a;
  logic          en_b, cu_b, cc_b, cl_b, bp_b;
  logic [TW-1:0] pr_b;
  logic [2:0]    st_b;

  int nvec = 0;
  int nmis = 0;

  always #5 clock = ~clock;

  stopwatch_ctrl #(.BEEP_CYCLES(8)) dut (
    .clock(clock), .reset_n(reset_n), .startstop(ss), .clear(clr), .prog(prg),
    .up(up), .increment(inc), .min(mn), .cnt_zero(cz), .cnt_max(cm),
    .cnt_en(en_a), .cnt_up(cu_a), .cnt_clear(cc_a), .cnt_load(cl_a),
    .preset_ms(pr_a), .state(st_a), .beep(bp_a)
  );

  stopwatch_ctrl #(.BEEP_CYCLES(8), .MAX_MS(5000)) dut_m (
    .clock(clock), .reset_n(reset_n), .startstop(ss), .clear(clr), .prog(prg),
    .up(up), .increment(inc), .min(mn), .cnt_zero(cz), .cnt_max(cm),
    .cnt_en(en_b), .cnt_up(cu_b), .cnt_clear(cc_b), .cnt_load(cl_b),
    .preset_ms(pr_b), .state(st_b), .beep(bp_b)
  );

  typedef struct {
    int ss, clr, prg, up, inc, mn, cz, cm;
    int st, en, cc, cl, cu, preset;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(int a_ss, int a_clr, int a_prg, int a_up, int a_inc, int a_mn,
                              int a_st, int a_en, int a_cc, int a_cl, int a_cu, int a_pr);
    vec_t v;
    v.ss = a_ss; v.clr = a_clr; v.prg = a_prg; v.up = a_up; v.inc = a_inc; v.mn = a_mn;
    v.cz = 0; v.cm = 0;
    v.st = a_st; v.en = a_en; v.cc = a_cc; v.cl = a_cl; v.cu = a_cu; v.preset = a_pr;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #22;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  // ---------------- behavioural reference model ----------------
  int m_s, m_dir, m_pre, m_cc, m_cl, m_age, p_ss, p_clr, p_inc;

  task automatic model_reset();
    m_s = 0; m_dir = 1; m_pre = 60000; m_cc = 0; m_cl = 0; m_age = 0;
    p_ss = 1; p_clr = 1; p_inc = 1;
  endtask

  // Applies one clock edge's worth of rules using the inputs present now.
  task automatic model_step();
    int ssp, cp, ip, ns, sum;
    ssp = (ss && !p_ss) ? 1 : 0;
    cp  = (clr && !p_clr) ? 1 : 0;
    ip  = (inc && !p_inc) ? 1 : 0;
    p_ss = ss; p_clr = clr; p_inc = inc;
    ns = m_s; m_cc = 0; m_cl = 0;
    if (m_s == 0) begin
      if (cp) ns = 0;
      else if (prg) ns = 3;
      else if (ssp && (up || m_pre != 0)) begin
        m_dir = up; m_cc = up; m_cl = !up; ns = 1;
      end
    end else if (m_s == 1) begin
      if (cp) ns = 0;
      else if (ssp) ns = 2;
      else if (!m_dir && cz) ns = 4;
      else if (m_dir && cm) ns = 2;
    end else if (m_s == 2) begin
      if (cp) ns = 0;
      else if (prg) ns = 3;
      else if (ssp) ns = 1;
    end else if (m_s == 3) begin
      if (cp) m_pre = 0;
      else if (!prg) ns = 0;
      else if (ip) begin
        sum = m_pre + (mn ? 60000 : 1000);
        m_pre = (sum > 5999999) ? 0 : sum;
      end
    end else begin
      if (cp || ssp) ns = 0;
    end
    if (ns == 0 && m_s != 0) begin
      m_dir = up; m_cc = up; m_cl = !up;
    end
    if (ns == 4 && m_s != 4) m_age = 0;
    else if (m_s == 4) m_age++;
    m_s = ns;
  endtask

  initial begin
    int n;

    // Test 1: startstop held through reset release is not a press.
    ss = 1; up = 1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      chk("hold.state", st_a, 0);
      chk("hold.en", en_a, 0);
      chk("hold.beep", bp_a, 0);
      chk("hold.preset", pr_a, 60000);
      chk("hold.clr", cc_a, 0);
      chk("hold.load", cl_a, 0);
      tick();
    end
    ss = 0;
    tick();

    // Tests 2/3 as a vector table.
    tbl[0]  = mk(1,0,0,1,0,0, 1,1,1,0,1,60000);
    tbl[1]  = mk(0,0,0,1,0,0, 1,1,0,0,1,60000);
    tbl[2]  = mk(1,0,0,1,0,0, 2,0,0,0,1,60000);
    tbl[3]  = mk(0,0,0,1,0,0, 2,0,0,0,1,60000);
    tbl[4]  = mk(0,1,0,1,0,0, 0,0,1,0,1,60000);
    tbl[5]  = mk(0,0,0,1,0,0, 0,0,0,0,1,60000);
    tbl[6]  = mk(0,0,1,1,0,0, 3,0,0,0,1,60000);
    tbl[7]  = mk(0,1,1,1,0,0, 3,0,0,0,1,0);
    tbl[8]  = mk(0,0,1,1,0,1, 3,0,0,0,1,0);
    tbl[9]  = mk(0,0,1,1,1,1, 3,0,0,0,1,60000);
    tbl[10] = mk(0,0,1,1,0,1, 3,0,0,0,1,60000);
    tbl[11] = mk(0,0,1,1,1,1, 3,0,0,0,1,120000);
    tbl[12] = mk(0,0,1,1,0,1, 3,0,0,0,1,120000);
    tbl[13] = mk(0,0,1,1,1,0, 3,0,0,0,1,121000);
    tbl[14] = mk(0,0,1,1,0,0, 3,0,0,0,1,121000);
    tbl[15] = mk(0,0,1,1,1,0, 3,0,0,0,1,122000);
    tbl[16] = mk(0,0,1,1,0,0, 3,0,0,0,1,122000);
    tbl[17] = mk(0,0,1,1,1,0, 3,0,0,0,1,123000);
    tbl[18] = mk(0,0,1,0,0,0, 3,0,0,0,1,123000);
    tbl[19] = mk(0,0,0,0,0,0, 0,0,0,1,0,123000);
    tbl[20] = mk(0,0,0,0,0,0, 0,0,0,0,0,123000);
    tbl[21] = mk(1,0,0,0,0,0, 1,1,0,1,0,123000);
    tbl[22] = mk(0,0,0,0,0,0, 1,1,0,0,0,123000);
    tbl[23] = mk(0,1,0,0,0,0, 0,0,0,1,0,123000);
    tbl[24] = mk(0,0,0,0,0,0, 0,0,0,0,0,123000);
    for (int i = 0; i < 25; i++) begin
      ss = tbl[i].ss[0]; clr = tbl[i].clr[0]; prg = tbl[i].prg[0]; up = tbl[i].up[0];
      inc = tbl[i].inc[0]; mn = tbl[i].mn[0]; cz = tbl[i].cz[0]; cm = tbl[i].cm[0];
      tick();
      chk($sformatf("tbl%0d.state", i), st_a, tbl[i].st);
      chk($sformatf("tbl%0d.en", i), en_a, tbl[i].en);
      chk($sformatf("tbl%0d.clr", i), cc_a, tbl[i].cc);
      chk($sformatf("tbl%0d.load", i), cl_a, tbl[i].cl);
      chk($sformatf("tbl%0d.up", i), cu_a, tbl[i].cu);
      chk($sformatf("tbl%0d.preset", i), pr_a, tbl[i].preset);
    end

    // Test 4: count-down expiry, beep length, exit with load.
    ss = 1; tick();
    chk("dn.state", st_a, 1);
    chk("dn.load", cl_a, 1);
    ss = 0; tick();
    chk("dn.en", en_a, 1);
    cz = 1; #1;
    chk("dn.en_zero", en_a, 0);
    chk("dn.still_run", st_a, 1);
    tick();
    chk("dn.done", st_a, 4);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (bp_a) n++;
      tick();
    end
    chk("dn.beep_len", n, 8);
    chk("dn.beep_off", bp_a, 0);
    cz = 0; ss = 1; tick();
    chk("dn.exit_state", st_a, 0);
    chk("dn.exit_load", cl_a, 1);
    chk("dn.exit_beep", bp_a, 0);
    ss = 0; tick();

    // Test 5: preset wrap at MAX_MS=5000 and zero-preset down start ignored.
    up = 1; prg = 0; mn = 0;
    do_reset();
    prg = 1; tick();
    chk("wrap.prog", st_b, 3);
    clr = 1; tick(); clr = 0; tick();
    chk("wrap.zero", pr_b, 0);
    for (int k = 1; k <= 5; k++) begin
      inc = 1; tick(); inc = 0; tick();
      chk($sformatf("wrap.inc%0d", k), pr_b, k * 1000);
    end
    inc = 1; tick(); inc = 0; tick();
    chk("wrap.wrapped", pr_b, 0);
    up = 0; prg = 0; tick();
    chk("wrap.idle", st_b, 0);
    chk("wrap.load", cl_b, 1);
    tick();
    ss = 1; tick();
    chk("wrap.ign_state", st_b, 0);
    chk("wrap.ign_clr", cc_b, 0);
    chk("wrap.ign_load", cl_b, 0);
    ss = 0; tick();
    chk("wrap.ign_state2", st_b, 0);

    // Test 6: clear beats startstop; async reset mid-run.
    up = 1;
    do_reset();
    prg = 1; tick();
    clr = 1; tick(); clr = 0;
    chk("ar.preset0", pr_a, 0);
    prg = 0; tick();
    chk("ar.idle", st_a, 0);
    ss = 1; tick(); ss = 0;
    chk("ar.run", st_a, 1);
    tick();
    clr = 1; ss = 1; tick();
    chk("ar.both_state", st_a, 0);
    chk("ar.both_clr", cc_a, 1);
    clr = 0; ss = 0; tick();
    ss = 1; tick(); ss = 0;
    chk("ar.run2", st_a, 1);
    chk("ar.en2", en_a, 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar.state", st_a, 0);
    chk("ar.en", en_a, 0);
    chk("ar.clr", cc_a, 0);
    chk("ar.up", cu_a, 1);
    chk("ar.preset", pr_a, 60000);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // Random stimulus against the model.
    ss = 0; clr = 0; prg = 0; up = 1; inc = 0; mn = 0; cz = 0; cm = 0;
    do_reset();
    model_reset();
    model_step();
    for (int c = 0; c < 3000; c++) begin
      ss  = ($urandom % 4) == 0;
      clr = ($urandom % 10) == 0;
      if (($urandom % 16) == 0) prg = ~prg;
      if (($urandom % 15) == 0) up = ~up;
      inc = ($urandom % 3) == 0;
      mn  = $urandom % 2;
      cz  = ($urandom % 6) == 0;
      cm  = ($urandom % 12) == 0;
      model_step();
      tick();
      chk("rnd.state", st_a, m_s);
      chk("rnd.en", en_a, (m_s == 1 && !(m_dir ? cm : cz)) ? 1 : 0);
      chk("rnd.clr", cc_a, m_cc);
      chk("rnd.load", cl_a, m_cl);
      chk("rnd.up", cu_a, m_dir);
      chk("rnd.preset", pr_a, m_pre);
      chk("rnd.beep", bp_a, (m_s == 4 && m_age < 8) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
